// File: rtl/msk_unmask_seq.sv
// msk_unmask_seq: serial share recombination. It folds a d-share Boolean sharing into its W-bit value, one share per cycle.
// Define MSK_UNMASK_REFRESH_EN to add the rnd port and ring-refresh the shares when they are captured.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_unmask_seq #(
    parameter int d = `DEFAULTSHARES,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [d*W-1:0] in_shares,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
`ifdef MSK_UNMASK_REFRESH_EN
    ,
    input  logic [d*W-1:0] rnd
`endif
);
    localparam int CW = $clog2(d);
    localparam logic [CW-1:0] LAST = CW'(d - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t              state, state_next;
    logic [d-1:0][W-1:0] share_reg;
    logic [d-1:0][W-1:0] captured;
    logic [W-1:0]        acc;
    logic [CW-1:0]       cnt;
    logic                accept;

    assign accept = in_valid && (state == IDLE);

    // Shares as they will be stored; a ring refresh keeps the XOR of all shares unchanged.
    always_comb begin
        for (int i = 0; i < d; i++) begin
`ifdef MSK_UNMASK_REFRESH_EN
            captured[i] = in_shares[i*W +: W] ^ rnd[i*W +: W] ^ rnd[((i + 1) % d)*W +: W];
`else
            captured[i] = in_shares[i*W +: W];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)       state_next = ACC;
            ACC:     if (cnt == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_data  = (state == DONE) ? acc : '0;
    end

    // NOTE: share_reg is reset and wiped after release, so no share outlives its transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            share_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    share_reg <= captured;
                    acc       <= captured[0];
                    cnt       <= CW'(1);
                end
                ACC: begin
                    acc <= acc ^ share_reg[cnt];
                    cnt <= cnt + 1'b1;
                end
                DONE: if (out_ready) begin
                    share_reg <= '0;
                    acc       <= '0;
                    cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msk_unmask_seq.sv
// Bench for msk_unmask_seq: instances at d=2, 3 and 4, directed steps, and a scoreboard of expected unmasked values.
// Define MSK_UNMASK_REFRESH_EN to also exercise the rnd port and the ring refresh.
module tb_msk_unmask_seq;
    logic        clk;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    logic [15:0] in_shares2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0]  out_data2;
    logic [23:0] in_shares3;
    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [7:0]  out_data3;
    logic [31:0] in_shares4;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  out_data4;
`ifdef MSK_UNMASK_REFRESH_EN
    logic [15:0] rnd2;
    logic [23:0] rnd3;
    logic [31:0] rnd4;
`endif

    logic [7:0] q2[$];
    logic [7:0] q3[$];
    logic [7:0] q4[$];
    int         pop2_times[$];

    msk_unmask_seq #(.d(2), .W(8)) dut2 (
        .clk(clk), .rst(rst), .in_shares(in_shares2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
`ifdef MSK_UNMASK_REFRESH_EN
        , .rnd(rnd2)
`endif
    );
    msk_unmask_seq #(.d(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .in_shares(in_shares3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MSK_UNMASK_REFRESH_EN
        , .rnd(rnd3)
`endif
    );
    msk_unmask_seq #(.d(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .in_shares(in_shares4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4)
`ifdef MSK_UNMASK_REFRESH_EN
        , .rnd(rnd4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [31:0] v, input int n);
        logic [7:0] r = '0;
        for (int i = 0; i < n; i++) r = r ^ v[i*8 +: 8];
        return r;
    endfunction

    task automatic pop_check(input string tag, input logic [7:0] obs, inout logic [7:0] q[$]);
        logic [7:0] exp;
        if (q.size() == 0) begin
            check({tag, "_unexpected_output"}, 32'(q.size()), 32'd1);
        end else begin
            exp = q.pop_front();
            check(tag, 32'(obs), 32'(exp));
        end
    endtask

    // One clock: scoreboard at the falling edge, then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (in_valid2 && in_ready2) q2.push_back(fold(32'(in_shares2), 2));
        if (in_valid3 && in_ready3) q3.push_back(fold(32'(in_shares3), 3));
        if (in_valid4 && in_ready4) q4.push_back(fold(in_shares4, 4));
        if (out_valid2 && out_ready2) begin
            pop_check("out2", out_data2, q2);
            pop2_times.push_back(cyc);
        end
        if (out_valid3 && out_ready3) pop_check("out3", out_data3, q3);
        if (out_valid4 && out_ready4) pop_check("out4", out_data4, q4);
        if (!out_valid2) check("zero_when_idle2", 32'(out_data2), 32'd0);
        if (!out_valid3) check("zero_when_idle3", 32'(out_data3), 32'd0);
        if (!out_valid4) check("zero_when_idle4", 32'(out_data4), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [15:0] tbl[3];
        rst = 1'b1;
        in_shares2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        in_shares3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
        in_shares4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;
`ifdef MSK_UNMASK_REFRESH_EN
        rnd2 = '0; rnd3 = '0; rnd4 = '0;
`endif
        cycle();
        cycle();
        check("rst_in_ready2", 32'(in_ready2), 32'd1);
        check("rst_out_valid2", 32'(out_valid2), 32'd0);
        check("rst_out_data2", 32'(out_data2), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        rst = 1'b0;
        cycle();

        // d=2: 0x3C ^ 0xA5 = 0x99; the accepting edge counts as the first of the d edges.
        in_shares2 = {8'hA5, 8'h3C};
        in_valid2  = 1'b1;
        check("d2_in_ready_idle", 32'(in_ready2), 32'd1);
        cycle();
        in_valid2 = 1'b0;
        check("d2_acc_valid", 32'(out_valid2), 32'd0);
        check("d2_acc_in_ready", 32'(in_ready2), 32'd0);
        cycle();
        check("d2_done_valid", 32'(out_valid2), 32'd1);
        check("d2_done_data", 32'(out_data2), 32'h99);
        cycle();
        check("d2_back_to_idle", 32'(in_ready2), 32'd1);
        check("d2_q_empty", 32'(q2.size()), 32'd0);

        // d=3: 0x01 ^ 0x02 ^ 0x04 = 0x07, two ACC cycles with out_data held at 0.
        in_shares3 = {8'h04, 8'h02, 8'h01};
        in_valid3  = 1'b1;
        cycle();
        in_valid3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("d3_acc_valid", 32'(out_valid3), 32'd0);
            check("d3_acc_data", 32'(out_data3), 32'd0);
            cycle();
        end
        check("d3_done_valid", 32'(out_valid3), 32'd1);
        check("d3_done_data", 32'(out_data3), 32'h07);
        cycle();
        check("d3_q_empty", 32'(q3.size()), 32'd0);

        // Back-to-back at d=2 with in_valid held high.
        tbl[0] = {8'h0F, 8'hF0};
        tbl[1] = {8'h81, 8'h18};
        tbl[2] = {8'h5A, 8'h5A};
        pop2_times.delete();
        in_valid2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_shares2 = tbl[k];
            check("b2b_in_ready", 32'(in_ready2), 32'd1);
            cycle();
            cycle();
            cycle();
        end
        in_valid2 = 1'b0;
        check("b2b_count", 32'(pop2_times.size()), 32'd3);
        if (pop2_times.size() == 3) begin
            check("b2b_spacing01", 32'(pop2_times[1] - pop2_times[0]), 32'd3);
            check("b2b_spacing12", 32'(pop2_times[2] - pop2_times[1]), 32'd3);
        end
        check("b2b_q_empty", 32'(q2.size()), 32'd0);

        // Backpressure at d=2: 0x12 ^ 0x34 = 0x26 held for five DONE cycles.
        in_shares2 = {8'h34, 8'h12};
        in_valid2  = 1'b1;
        cycle();
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            in_shares2 = {8'h0F, 8'h55};
            in_valid2  = 1'b1;
            check("bp_valid", 32'(out_valid2), 32'd1);
            check("bp_data", 32'(out_data2), 32'h26);
            check("bp_in_ready", 32'(in_ready2), 32'd0);
            cycle();
        end
        out_ready2 = 1'b1;
        cycle();
        check("bp_release_idle", 32'(in_ready2), 32'd1);
        check("bp_release_valid", 32'(out_valid2), 32'd0);
        check("bp_no_early_accept", 32'(q2.size()), 32'd0);
        cycle();
        in_valid2 = 1'b0;
        cycle();
        check("bp_next_valid", 32'(out_valid2), 32'd1);
        check("bp_next_data", 32'(out_data2), 32'h5A);
        cycle();
        check("bp_q_empty", 32'(q2.size()), 32'd0);

        // Reset during the second ACC cycle at d=4 discards the transaction.
        in_shares4 = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid4  = 1'b1;
        cycle();
        in_valid4 = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready4), 32'd1);
        check("midrst_out_valid", 32'(out_valid4), 32'd0);
        check("midrst_out_data", 32'(out_data4), 32'd0);
        q4.delete();
        #1;
        rst = 1'b0;
        in_shares4 = {8'hF0, 8'h0F, 8'h00, 8'hFF};
        in_valid4  = 1'b1;
        cycle();
        in_valid4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("d4_acc_valid", 32'(out_valid4), 32'd0);
            cycle();
        end
        check("d4_done_valid", 32'(out_valid4), 32'd1);
        check("d4_done_data", 32'(out_data4), 32'h00);
        cycle();
        check("d4_q_empty", 32'(q4.size()), 32'd0);

`ifdef MSK_UNMASK_REFRESH_EN
        // Ring refresh at d=3: share 0 becomes 0x11 ^ 0xAA ^ 0x55 = 0xEE, unmasked value stays 0x77.
        in_shares3 = {8'h44, 8'h22, 8'h11};
        rnd3       = {8'hF0, 8'h55, 8'hAA};
        in_valid3  = 1'b1;
        cycle();
        in_valid3 = 1'b0;
        rnd3      = 24'h3C_96_E1;
        check("refresh_share0", 32'(dut3.share_reg[0]), 32'hEE);
        check("refresh_share1", 32'(dut3.share_reg[1]), 32'h87);
        cycle();
        cycle();
        check("refresh_valid", 32'(out_valid3), 32'd1);
        check("refresh_data", 32'(out_data3), 32'h77);
        cycle();
        check("refresh_q_empty", 32'(q3.size()), 32'd0);
`endif

        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msk_unmask_seq.md
Name: msk_unmask_seq

Overview:
- Sequential share-recombination (unmasking) unit: the decoder-side counterpart of the masked gadgets. It accepts a d-share Boolean sharing of a W-bit value and releases the unmasked value.
- Recombination is serial, one share folded per cycle, so no combinational cone ever touches all shares at once.
- Sits at the boundary where masked datapaths (AND/XOR gadget outputs) hand results to unmasked logic, e.g. ciphertext output.
- valid/ready handshake on both sides; one transaction in flight at a time.

Parameters:
- d, `DEFAULTSHARES (2), number of shares; legal range d >= 2.
- W, 8, bit width of the shared value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_shares  input  d*W  sharing, share i at bits [i*W +: W].
- in_valid  input  1  in_shares valid.
- in_ready  output  1  block can accept a sharing.
- out_data  output  W  unmasked value.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- rnd  input  d*W  refresh randomness, word i at bits [i*W +: W]; present only with MSK_UNMASK_REFRESH_EN.

Behaviour:
- State machine with states IDLE, ACC and DONE. Internal registers:
  - share_reg: d*W bits.
  - acc: W bits.
  - cnt: clog2(d) bits.
- Reset (asynchronous, at any time, including mid-ACC or in DONE):
  - state=IDLE; share_reg, acc and cnt all cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0.
  - An in-flight transaction is discarded silently.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: share_reg<=in_shares, acc<=in_shares[0 +: W], cnt<=1, state<=ACC.
- ACC:
  - in_ready=0, out_valid=0.
  - Each cycle: acc<=acc^share_reg[cnt*W +: W], cnt<=cnt+1.
  - When cnt==d-1 (the last share is folded this cycle), state<=DONE.
  - ACC lasts exactly d-1 cycles.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - Holds indefinitely while out_ready=0; out_data stays stable.
  - On out_ready=1: state<=IDLE, share_reg<=0, acc<=0, cnt<=0 (share wipe).
- Latency: out_valid rises exactly d rising edges after the accepting edge. Minimum throughput is one sharing per d+1 cycles.
- out_data is forced to 0 whenever out_valid=0, so partial sums are never visible on the port.
- in_valid outside IDLE is ignored; in_shares need not be held after acceptance.
- in_valid while out_ready is asserted in DONE: no same-cycle accept. The new sharing is accepted in the following IDLE cycle.
- Arithmetic: bitwise XOR only, no carries.

Optional Feature:
- Macro: MSK_UNMASK_REFRESH_EN.
- Defined:
  - rnd port exists.
  - On accept, share_reg[i] <= in_shares[i] ^ rnd[i] ^ rnd[(i+1) mod d] (ring refresh). acc is seeded from the refreshed share 0.
  - The unmasked value is unchanged.
  - No added latency.
  - rnd is sampled only on the accepting edge.
- Undefined:
  - No rnd port.
  - Shares are captured verbatim.

Test Plan:
- d=2, W=8, in_shares={0x3C,0xA5}, out_ready=1 -> out_valid high 2 edges after accept, out_data=0x99; in_ready back to 1 one cycle later.
- d=3, W=8, shares 0x01,0x02,0x04 -> out_data=0x07 exactly 3 edges after accept; out_data=0x00 during all ACC cycles.
- Backpressure: d=2, out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay constant, in_ready=0, further in_valid ignored; release out_ready -> next sharing accepted in the IDLE cycle.
- Reset mid-ACC: d=4, assert rst during the 2nd ACC cycle -> immediately in_ready=1, out_valid=0, out_data=0; a subsequent sharing of 0xFF,0x00,0x0F,0xF0 yields 0x00.
- Back-to-back: in_valid held high with 3 different sharings at d=2 -> 3 correct results, each separated by d+1=3 cycles, none lost or duplicated.
- MSK_UNMASK_REFRESH_EN, d=3: shares 0x11,0x22,0x44 with rnd words 0xAA,0x55,0xF0 -> out_data=0x77; share_reg[0] captured as 0x11^0xAA^0x55=0xEE.
